uart_tx_fifo: RTL and testbench

- Memory-mapped UART transmitter peripheral on the shared CPU/debug bus, decoded from the MMIO window like the other peripherals.
- The bus writes bytes into a FIFO. A shift FSM drains the FIFO onto a serial line as 8N1 frames.
- Responds on the OR-combined read bus: it drives zeros whenever it is not selected.
- Lets firmware queue whole strings without polling per byte.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM encoding, STATUS bit positions, baud divisor math.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_ACTIVE = 2;
  localparam int unsigned STAT_OVF    = 3;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read port; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally; count is one bit wider to tell full from empty.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// MMIO UART transmitter: bus writes fill a FIFO that a shift FSM drains as 8N1 frames.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 1000000,
  parameter int unsigned UART_FREQ  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       cs,
  input  logic       data_reg,
  input  logic       wren,
  input  logic [7:0] di,
  output logic [7:0] dout,
  output logic       tx,
  output logic       tx_idle
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, UART_FREQ);
  localparam int unsigned BW  = $clog2(DIV) + 1;

  tx_state_e   state;
  tx_state_e   state_next;
  logic        cs_q;
  logic        access;
  logic        data_wr;
  logic        status_rd;
  logic        push;
  logic        drop;
  logic        pop;
  logic        ovf;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [7:0]  status;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_next;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        tx_next;

  // One access per cs assertion, on its first cycle.
  assign access    = cs & ~cs_q;
  assign data_wr   = access & wren & data_reg;
  assign status_rd = access & ~wren & ~data_reg;
  assign push      = data_wr & ~fifo_full;
  assign drop      = data_wr & fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .pop     (pop),
    .din     (di),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    status              = '0;
    status[STAT_EMPTY]  = fifo_empty;
    status[STAT_FULL]   = fifo_full;
    status[STAT_ACTIVE] = (state != ST_IDLE);
    status[STAT_OVF]    = ovf;
  end

  // Bus side: read mux and sticky overflow (a drop wins over a clearing read).
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cs_q <= 1'b0;
      ovf  <= 1'b0;
      dout <= 8'h00;
    end else begin
      cs_q <= cs;
      ovf  <= (ovf & ~status_rd) | drop;
      dout <= cs ? (data_reg ? 8'h00 : status) : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_next = ST_START;
      ST_START: if (baud_cnt == '0) state_next = ST_DATA;
      ST_DATA:  if (baud_cnt == '0 && bit_idx == 3'd7) state_next = ST_STOP;
      ST_STOP:  if (baud_cnt == '0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // tx_next is the line level for the state being entered, keeping tx registered.
  always_comb begin
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_dout;
          baud_next  = BW'(DIV - 1);
          tx_next    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_cnt == '0) begin
          baud_next = BW'(DIV - 1);
          bit_next  = '0;
          tx_next   = shift[0];
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_cnt == '0) begin
          baud_next = BW'(DIV - 1);
          if (bit_idx == 3'd7) begin
            tx_next = 1'b1;
          end else begin
            shift_next = {1'b0, shift[7:1]};
            bit_next   = bit_idx + 3'd1;
            tx_next    = shift[1];
          end
        end else begin
          baud_next = baud_cnt - BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_cnt == '0) tx_next = 1'b1;
        else                baud_next = baud_cnt - BW'(1);
      end
      default: ;
    endcase
  end

  // Entering IDLE implies no pop, so the FIFO is empty next cycle iff empty now and no push.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_idle  <= 1'b1;
    end else begin
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx       <= tx_next;
      tx_idle  <= (state_next == ST_IDLE) & fifo_empty & ~push;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: serial and bus monitors check against queued expectations.
module tb_uart_tx_fifo;

  localparam int DIV = 9;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       cs = 1'b0;
  logic       data_reg = 1'b0;
  logic       wren = 1'b0;
  logic [7:0] di = 8'h00;
  logic [7:0] dout;
  logic       tx;
  logic       tx_idle;

  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  int         start_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_starts = 0;
  int         n_frames = 0;
  int         rst_cnt = 0;
  int         cyc = 0;
  logic       rd_pending = 1'b0;

  uart_tx_fifo #(
    .CLK_FREQ   (1000000),
    .UART_FREQ  (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .cs       (cs),
    .data_reg (data_reg),
    .wren     (wren),
    .di       (di),
    .dout     (dout),
    .tx       (tx),
    .tx_idle  (tx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge n_reset) rst_cnt <= rst_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic dreg, input logic [7:0] val, input int hold,
                           input logic expect_tx);
    @(negedge clk);
    cs = 1'b1; data_reg = dreg; wren = 1'b1; di = val;
    if (expect_tx) exp_q.push_back(val);
    repeat (hold) @(negedge clk);
    cs = 1'b0; wren = 1'b0;
  endtask

  task automatic bus_read(input logic dreg, input logic [7:0] exp);
    @(negedge clk);
    cs = 1'b1; data_reg = dreg; wren = 1'b0;
    rd_q.push_back(exp);
    rd_pending = 1'b1;
    @(negedge clk);
    rd_pending = 1'b0;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int k = 0;
    @(negedge clk);
    while (tx_idle !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, int'(tx_idle), 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Bus monitor: read data is valid one clock after cs rises.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_pending) begin
        #1;
        if (rd_q.size() == 0) chk("rd_unexpected", int'(dout), -1);
        else                  chk("bus_read", int'(dout), int'(rd_q.pop_front()));
      end
    end
  end

  // Serial monitor: decode 8N1 frames at mid-bit; frames cut by reset are discarded.
  initial begin
    logic [7:0] b;
    logic       sb;
    logic       pb;
    int         r0;
    forever begin
      @(negedge clk);
      if (n_reset === 1'b1 && tx === 1'b0) begin
        r0 = rst_cnt;
        n_starts++;
        start_q.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        pb = tx;
        if (rst_cnt == r0) begin
          n_frames++;
          chk("start_bit", int'(sb), 0);
          chk("stop_bit", int'(pb), 1);
          if (exp_q.size() == 0) chk("unexpected_frame", int'(b), -1);
          else                   chk("frame_byte", int'(b), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int f0;
    int s0;
    int s1;
    int d;

    // Reset state and idle line
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_tx_idle", int'(tx_idle), 1);
    chk("rst_dout", int'(dout), 0);
    n_reset = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_tx", int'(tx), 1);
    chk("idle_tx_idle", int'(tx_idle), 1);
    bus_read(1'b0, 8'h01);
    bus_read(1'b1, 8'h00);

    // Single frame: start latency 2 clk, frame 90 clk, tx_idle 92 clk after cs
    start_q.delete();
    @(negedge clk);
    t0 = cyc + 1;
    bus_write(1'b1, 8'hA5, 2, 1'b1);
    wait_idle(300, "single");
    chk("single_starts", start_q.size(), 1);
    if (start_q.size() > 0) chk("single_latency", start_q[0] - t0, 2);
    chk("single_idle_at", cyc - t0, 92);

    // Back-to-back frames: order and 91 clk pitch, active during stream
    start_q.delete();
    bus_write(1'b1, 8'h41, 2, 1'b1);
    bus_write(1'b1, 8'h42, 2, 1'b1);
    bus_write(1'b1, 8'h43, 2, 1'b1);
    bus_read(1'b0, 8'h04);
    wait_idle(500, "b2b");
    chk("b2b_starts", start_q.size(), 3);
    if (start_q.size() == 3) begin
      chk("b2b_pitch1", start_q[1] - start_q[0], 10 * DIV + 1);
      chk("b2b_pitch2", start_q[2] - start_q[1], 10 * DIV + 1);
    end

    // Overflow: one frame in flight, 16 fill the FIFO, the 17th is dropped
    bus_write(1'b1, 8'h00, 2, 1'b1);
    for (int i = 0; i < 17; i++) bus_write(1'b1, 8'(8'h10 + i), 2, i < 16);
    bus_read(1'b0, 8'h0E);
    bus_read(1'b0, 8'h06);
    wait_idle(2200, "ovf");
    bus_read(1'b0, 8'h01);

    // Long cs hold still gives exactly one push
    f0 = n_frames;
    bus_write(1'b1, 8'h77, 5, 1'b1);
    wait_idle(300, "hold");
    chk("hold_frames", n_frames - f0, 1);

    // Reset during bit 4 of 0xC3 (bit 4 = 0): line snaps high, queue lost
    s0 = n_starts;
    bus_write(1'b1, 8'hC3, 2, 1'b0);
    bus_write(1'b1, 8'h5A, 2, 1'b0);
    d = 0;
    while (n_starts == s0 && d < 20) begin
      @(negedge clk);
      d++;
    end
    chk("rst_frame_started", n_starts - s0, 1);
    d = (start_q.size() > 0) ? start_q[start_q.size() - 1] : cyc;
    while (cyc < d + DIV + 4 * DIV + DIV / 2) @(negedge clk);
    chk("pre_rst_bit4", int'(tx), 0);
    n_reset = 1'b0;
    #1;
    chk("async_rst_tx", int'(tx), 1);
    chk("async_rst_dout", int'(dout), 0);
    chk("async_rst_idle", int'(tx_idle), 1);
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    s1 = n_starts;
    bus_read(1'b0, 8'h01);
    repeat (300) @(negedge clk);
    chk("post_rst_no_frames", n_starts - s1, 0);
    chk("post_rst_tx", int'(tx), 1);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
